// File: rtl/vc_flit_tx.sv
// rtl/vc_flit_tx.sv - round-robin, packet-locking flit transmitter onto a registered link stage
module vc_flit_tx #(
    parameter int N_VC   = 3,
    parameter int FLIT_W = 34
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic [N_VC*FLIT_W-1:0]   fdata_i,
    input  logic [N_VC-1:0]          valid_i,
    output logic [N_VC-1:0]          ready_o,
    output logic [FLIT_W-1:0]        fdata_o,
    output logic [1:0]               vc_id_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic                     proto_err_o
);

    // Locked means a multi-flit packet is in flight and only lock_vc may send.
    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_t;

    localparam logic [1:0] TYPE_HEAD = 2'b00;
    localparam logic [1:0] TYPE_BODY = 2'b01;
    localparam logic [1:0] TYPE_TAIL = 2'b11;
    localparam logic [1:0] TYPE_RSVD = 2'b10;
    localparam logic [2:0] NVC3      = 3'(N_VC);

    lock_state_t        state_q, state_d;
    logic [1:0]         lock_vc_q, lock_vc_d;
    logic [1:0]         rr_q, rr_d;
    logic               valid_q, valid_d;
    logic [FLIT_W-1:0]  data_q, data_d;
    logic [1:0]         vc_q, vc_d;
    logic               err_q, err_d;

    logic               take;
    logic [3:0]         elig;
    logic [3:0]         grant_oh;
    logic [1:0]         grant_idx;
    logic               grant_vld;
    logic [2:0]         scan;
    logic               xfer;
    logic [FLIT_W-1:0]  sel_flit;
    logic [1:0]         sel_type;
    logic [7:0]         sel_size;
    logic [2:0]         rr_next;

    // Arbitration: eligibility mask, then first eligible VC at or after rr_q.
    always_comb begin
        take = !valid_q || ready_i;
        elig = 4'(valid_i);
        if (state_q == ST_LOCKED) begin
            elig = elig & (4'b0001 << lock_vc_q);
        end
        grant_vld = 1'b0;
        grant_idx = 2'd0;
        scan      = 3'd0;
        for (int k = 0; k < N_VC; k++) begin
            scan = {1'b0, rr_q} + 3'(k);
            if (scan >= NVC3) begin
                scan = scan - NVC3;
            end
            if (!grant_vld && elig[scan[1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = scan[1:0];
            end
        end
        grant_oh = 4'b0000;
        if (take && grant_vld && !arst) begin
            grant_oh = 4'b0001 << grant_idx;
        end
    end

    assign ready_o = grant_oh[N_VC-1:0];
    assign xfer    = |grant_oh;

    // Next state: load output stage on transfer, track packet lock and protocol errors.
    always_comb begin
        state_d   = state_q;
        lock_vc_d = lock_vc_q;
        rr_d      = rr_q;
        valid_d   = valid_q;
        data_d    = data_q;
        vc_d      = vc_q;
        err_d     = err_q;
        sel_flit  = fdata_i[int'(grant_idx)*FLIT_W +: FLIT_W];
        sel_type  = sel_flit[FLIT_W-1 -: 2];
        sel_size  = sel_flit[29:22];
        rr_next   = {1'b0, grant_idx} + 3'd1;
        if (rr_next >= NVC3) begin
            rr_next = 3'd0;
        end
        if (xfer) begin
            valid_d = 1'b1;
            data_d  = sel_flit;
            vc_d    = grant_idx;
            case (state_q)
                ST_OPEN: begin
                    rr_d = rr_next[1:0];
                    if (sel_type == TYPE_HEAD && sel_size != 8'd0) begin
                        state_d   = ST_LOCKED;
                        lock_vc_d = grant_idx;
                    end
                    if (sel_type == TYPE_BODY || sel_type == TYPE_TAIL) begin
                        err_d = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (sel_type == TYPE_HEAD) begin
                        err_d = 1'b1;
                    end
                    if (sel_type == TYPE_TAIL) begin
                        state_d = ST_OPEN;
                    end
                end
                default: state_d = ST_OPEN;
            endcase
            if (sel_type == TYPE_RSVD) begin
                err_d = 1'b1;
            end
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (arst) begin
            state_q   <= ST_OPEN;
            lock_vc_q <= 2'd0;
            rr_q      <= 2'd0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            vc_q      <= 2'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lock_vc_q <= lock_vc_d;
            rr_q      <= rr_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            vc_q      <= vc_d;
            err_q     <= err_d;
        end
    end

    assign valid_o     = valid_q;
    assign fdata_o     = data_q;
    assign vc_id_o     = vc_q;
    assign proto_err_o = err_q;

endmodule

// File: tb/tb_vc_flit_tx.sv
// tb/tb_vc_flit_tx.sv - scoreboard bench for vc_flit_tx with a behavioural reference model
module tb_vc_flit_tx;

    localparam int N = 3;
    localparam int W = 34;

    logic             clk = 1'b0;
    logic             arst = 1'b1;
    logic [N*W-1:0]   fdata_i = '0;
    logic [N-1:0]     valid_i = '0;
    logic [N-1:0]     ready_o;
    logic [W-1:0]     fdata_o;
    logic [1:0]       vc_id_o;
    logic             valid_o;
    logic             ready_i = 1'b0;
    logic             proto_err_o;

    vc_flit_tx #(.N_VC(N), .FLIT_W(W)) dut (
        .clk(clk), .arst(arst), .fdata_i(fdata_i), .valid_i(valid_i), .ready_o(ready_o),
        .fdata_o(fdata_o), .vc_id_o(vc_id_o), .valid_o(valid_o), .ready_i(ready_i),
        .proto_err_o(proto_err_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [W-1:0]  src_q [N][$];
    logic [W+1:0]  sb_q [$];
    int            payload = 1;

    int  m_locked = 0;
    int  m_lockvc = 0;
    int  m_rr = 0;
    int  m_err = 0;
    int  m_vout = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic mk_flit(input logic [1:0] t, input logic [7:0] sz, output logic [W-1:0] f);
        f = {t, 2'b00, sz, 22'(payload)};
        payload++;
    endtask

    task automatic add_pkt(input int v, input int len);
        logic [W-1:0] f;
        mk_flit(2'b00, (len == 1) ? 8'd0 : 8'(len - 1), f);
        src_q[v].push_back(f);
        for (int i = 0; i < len - 2; i++) begin
            mk_flit(2'b01, 8'd0, f);
            src_q[v].push_back(f);
        end
        if (len > 1) begin
            mk_flit(2'b11, 8'd0, f);
            src_q[v].push_back(f);
        end
    endtask

    task automatic clear_src();
        for (int v = 0; v < N; v++) src_q[v].delete();
    endtask

    // One link cycle: check current state, drive inputs, predict grant, advance model.
    task automatic step(input logic rdy, input logic rst, input int gap);
        logic [N-1:0] vld;
        logic [N-1:0] exp_rdy;
        logic [W-1:0] f;
        int gi;
        int was_locked;
        @(posedge clk);
        #1;
        chk("valid_o", valid_o, m_vout);
        chk("proto_err_o", proto_err_o, m_err);
        arst = rst;
        ready_i = rdy;
        for (int v = 0; v < N; v++) begin
            vld[v] = (src_q[v].size() > 0) && ($urandom_range(99) >= gap);
            fdata_i[v*W +: W] = (src_q[v].size() > 0) ? src_q[v][0] : '0;
        end
        valid_i = vld;
        #1;
        gi = -1;
        if (!rst && (m_vout == 0 || rdy)) begin
            for (int k = 0; k < N; k++) begin
                int v;
                v = (m_rr + k) % N;
                if (gi < 0 && vld[v] && (m_locked == 0 || v == m_lockvc)) gi = v;
            end
        end
        exp_rdy = (gi >= 0) ? N'(1 << gi) : '0;
        chk("ready_o", ready_o, exp_rdy);
        if (rst) begin
            m_locked = 0; m_lockvc = 0; m_rr = 0; m_err = 0; m_vout = 0;
            sb_q.delete();
        end else if (gi >= 0) begin
            f = src_q[gi].pop_front();
            sb_q.push_back({2'(gi), f});
            was_locked = m_locked;
            if (f[W-1 -: 2] == 2'b10) m_err = 1;
            if (was_locked != 0) begin
                if (f[W-1 -: 2] == 2'b00) m_err = 1;
                if (f[W-1 -: 2] == 2'b11) m_locked = 0;
            end else begin
                m_rr = (gi + 1) % N;
                if (f[W-1 -: 2] == 2'b01 || f[W-1 -: 2] == 2'b11) m_err = 1;
                if (f[W-1 -: 2] == 2'b00 && f[29:22] != 8'd0) begin
                    m_locked = 1;
                    m_lockvc = gi;
                end
            end
            m_vout = 1;
        end else if (rdy) begin
            m_vout = 0;
        end
    endtask

    // Monitor: each completed link handshake must match the oldest expected flit.
    always @(negedge clk) begin
        if (!arst && valid_o === 1'b1 && ready_i === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_flit", {vc_id_o, fdata_o}, 36'h0);
                total--;
                if (bad == 0) bad++;
            end else begin
                chk("link_flit", {vc_id_o, fdata_o}, sb_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [35:0] held;
        logic [W-1:0] f;
        // Reset held two cycles with every source valid.
        for (int v = 0; v < N; v++) add_pkt(v, 1);
        arst = 1'b1;
        @(posedge clk);
        step(1'b0, 1'b1, 0);
        step(1'b0, 1'b1, 0);
        chk("reset_fdata_o", fdata_o, '0);
        chk("reset_vc_id_o", vc_id_o, 2'd0);
        chk("reset_valid_o", valid_o, 1'b0);

        // Round-robin with single-flit heads; first grant goes to VC0.
        for (int i = 0; i < 5; i++) for (int v = 0; v < N; v++) add_pkt(v, 1);
        for (int i = 0; i < 18; i++) step(1'b1, 1'b0, 0);

        // Lock: VC1 four-flit packet while VC0 and VC2 stay busy.
        clear_src();
        add_pkt(1, 4);
        for (int i = 0; i < 4; i++) begin add_pkt(0, 1); add_pkt(2, 1); end
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 0);

        // Backpressure mid-packet.
        clear_src();
        add_pkt(0, 8);
        add_pkt(2, 3);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0);
        for (int s = 0; s < 5; s++) begin
            step(1'b0, 1'b0, 0);
            if (s == 0) held = {vc_id_o, fdata_o};
            else chk("stall_hold", {vc_id_o, fdata_o}, held);
        end
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 0);

        // Randomized traffic, backpressure, source gaps and occasional reset.
        for (int c = 0; c < 700; c++) begin
            logic r;
            for (int v = 0; v < N; v++)
                if (src_q[v].size() < 3 && $urandom_range(3) == 0) add_pkt(v, $urandom_range(1, 5));
            r = ($urandom_range(149) == 0);
            step(r ? 1'b0 : ($urandom_range(3) != 0), r, 25);
            if (r) clear_src();
        end

        // Protocol error: body on idle VC0 while unlocked.
        step(1'b0, 1'b1, 0);
        clear_src();
        mk_flit(2'b01, 8'd0, f);
        src_q[0].push_back(f);
        step(1'b1, 1'b0, 0);
        add_pkt(1, 1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 0);
        chk("proto_err_sticky", proto_err_o, 1'b1);

        // Mid-packet reset, then a new head on VC2 granted at once.
        step(1'b0, 1'b1, 0);
        clear_src();
        add_pkt(1, 4);
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b0, 0);
        step(1'b0, 1'b1, 0);
        clear_src();
        add_pkt(2, 2);
        step(1'b1, 1'b0, 0);
        chk("post_reset_err", proto_err_o, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 0);

        @(negedge clk);
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vc_flit_tx.md
# vc_flit_tx

Flit transmitter for a NoC output link. It merges up to four per-VC flit sources onto the single 34-bit link consumed by the downstream `vc_buffer`. Arbitration is round-robin with packet locking, so flits of a multi-flit packet are never interleaved with other VCs. The output is a registered valid/ready stage. It sits between router switch allocation and the link wires, as the sending end of the `fdata`/`valid`/`ready`/`vc_id` interface.

## Interface
- `N_VC`, default 3: number of VC sources, 1..4.
- `FLIT_W`, default 34: flit width. Fixed encoding: bits [33:32] are the type (00 head, 01 body, 11 tail, 10 reserved). Bits [29:22] are the packet size field, meaningful on head flits only.

- `clk`  in  1  link clock; all state updates on the rising edge.
- `arst`  in  1  reset; synchronous, active-high.
- `fdata_i`  in  N_VC*FLIT_W  per-VC flits; VC i occupies bits [i*FLIT_W +: FLIT_W].
- `valid_i`  in  N_VC  per-VC flit valid.
- `ready_o`  out  N_VC  per-VC accept; one-hot or zero.
- `fdata_o`  out  FLIT_W  link flit.
- `vc_id_o`  out  2  VC index of `fdata_o`.
- `valid_o`  out  1  link valid.
- `ready_i`  in  1  downstream accept.
- `proto_err_o`  out  1  sticky protocol-error flag.

## Operation
- **State:**
  - output register (`valid_o`, `fdata_o`, `vc_id_o`)
  - `locked`, 1 bit
  - `lock_vc`, 2 bits
  - `rr_ptr`, 2 bits
  - `proto_err_o`
- **Slot free condition:** `take = !valid_o || ready_i`.
- **Eligibility:**
  - Locked: only `lock_vc` is eligible, and only if its `valid_i` is set.
  - Unlocked: every VC with `valid_i` set is eligible.
- **Grant:** the first eligible VC searching upward from `rr_ptr`, wrapping modulo N_VC. `ready_o[g] = take && eligible`. `ready_o` depends combinationally on `valid_i`; sources must not make `valid_i` depend on `ready_o`.
- **Transfer on VC g (`valid_i[g] && ready_o[g]`):**
  - Output register loads `fdata_i` slice g and `vc_id_o = g`.
  - If unlocked: `rr_ptr <= (g+1) mod N_VC`.
- **Lock set:** a head flit (type 00) with size [29:22] != 0 sets `locked=1`, `lock_vc=g`.
  - A head with size 0 is a single-flit packet and does not lock.
- **Lock clear:** a tail flit (type 11) from `lock_vc` clears `locked`. `rr_ptr` was already advanced when the head was granted.
- **Protocol errors** set `proto_err_o`, which stays set until reset:
  - body or tail flit accepted while unlocked, or
  - head flit accepted while locked, or
  - type 10 accepted.
- **Error-flit handling:** these flits are still forwarded. Lock state changes only as defined above.
- **Drain without refill:** `ready_i && !valid_o_next_src` (no transfer) clears `valid_o`. Data holds its last value.

## Timing
- **Reset values (cycle after `arst` high):**
  - `valid_o=0`, `fdata_o=0`, `vc_id_o=0`, `proto_err_o=0`
  - `locked=0`, `lock_vc=0`, `rr_ptr=0`
  - `ready_o=0` while `arst` is high
- **Latency:** a flit accepted in cycle t appears on the link with `valid_o=1` in cycle t+1.
- **Throughput:** one flit per cycle while `ready_i=1`. A drain and a refill in the same cycle cause no bubble.
- **Stall:** while `valid_o && !ready_i`, `fdata_o`/`vc_id_o` hold stable and all `ready_o=0`.
- **Simultaneous events:**
  - Tail accept and a new head on another VC in the same cycle: the tail wins; the other VC is considered the next cycle.
  - Lock-clear and lock-set cannot occur in one cycle, since one grant is made per cycle.
- **Wrap-around:** `rr_ptr` wraps from N_VC-1 to 0; it never holds a value >= N_VC.
- **Reset mid-packet:** the lock and any pending output flit are discarded with no flush. Sources must restart on a head flit.

## Test plan
- **Reset:** hold `arst` 2 cycles with all `valid_i=1` -> `ready_o=000`, `valid_o=0`, `fdata_o=0`; the first grant after release goes to VC0.
- **Round-robin:** single-flit heads (size 0) continuously on VC0..2, `ready_i=1` -> `vc_id_o` sequence 0,1,2,0,1,2…, one flit per cycle, first output 1 cycle after release.
- **Lock:**
  - Stimulus: VC1 sends head (size 3) + body + body + tail while VC0 and VC2 are always valid.
  - Required response: `vc_id_o` = 1,1,1,1 with no interleaving. The next grant goes to VC2, then VC0.
- **Backpressure:** `ready_i=0` for 5 cycles mid-packet -> `fdata_o`/`vc_id_o` stable, `ready_o=000`. On release the stream resumes with no lost or duplicated flit (check by flit payload counter).
- **Protocol error:** body flit on idle VC0 while unlocked -> forwarded, `proto_err_o=1` next cycle and stays 1 until reset.
- **Mid-packet reset:** assert `arst` after the head and 1 body -> `locked=0`, `valid_o=0`. A new head on VC2 is granted immediately after release.
